// File: rtl/alu_seq.sv
// alu_seq: four-register sequencer that decodes 8-bit instructions and drives an 8-bit ALU.
// Latency: handshake at cycle N, done in N+3, result readable in N+4; one instruction per 4 cycles.
// Backpressure: instr_ready is high only in IDLE; instr_valid and ld_en are ignored in other states.
module alu_seq #(
  parameter logic [7:0] REG_INIT = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       instr_valid,
  output logic       instr_ready,
  input  logic [7:0] instr,
  input  logic       ld_en,
  input  logic [1:0] ld_addr,
  input  logic [7:0] ld_data,
  input  logic [1:0] rd_addr,
  output logic [7:0] rd_data,
  output logic       done,
  output logic       illegal,
  output logic       flag_c,
  output logic       flag_z
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    EXEC = 2'd2,
    WB   = 2'd3
  } state_t;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_INC = 4'b0010;
  localparam logic [3:0] OP_DEC = 4'b0100;
  localparam logic [3:0] OP_AND = 4'b1000;
  localparam logic [3:0] OP_OR  = 4'b1001;
  localparam logic [3:0] OP_NOT = 4'b1010;
  localparam logic [3:0] OP_XOR = 4'b1100;
  localparam logic [3:0] OP_SL  = 4'b1110;
  localparam logic [3:0] OP_SR  = 4'b0111;
  localparam logic [3:0] OP_NOP = 4'b0110;

  state_t     state, state_nxt;
  logic [7:0] regs [4];
  logic [3:0] op_q;
  logic [1:0] rd_q, rs_q;
  logic [7:0] a_q, b_q, res_q;
  logic       cy_q;
  logic       c_q, z_q;
  logic [8:0] alu_wide;
  logic       op_legal, op_writes, op_arith;

  assign rd_data = regs[rd_addr];
  assign flag_c  = c_q;
  assign flag_z  = z_q;

  // Opcode class decode: illegal and NOP never write a register or a flag.
  always_comb begin
    op_legal  = 1'b1;
    op_writes = 1'b1;
    op_arith  = 1'b0;
    case (op_q)
      OP_ADD, OP_SUB: op_arith = 1'b1;
      OP_NOP:         op_writes = 1'b0;
      OP_INC, OP_DEC, OP_AND, OP_OR, OP_NOT, OP_XOR, OP_SL, OP_SR: begin
      end
      default: begin
        op_legal  = 1'b0;
        op_writes = 1'b0;
      end
    endcase
  end

  // ALU: bit 8 is carry for ADD and borrow for SUB; for illegal opcodes the
  // result is a don't-care that the write-back decode masks off.
  always_comb begin
    alu_wide = 9'd0;
    case (op_q)
      OP_ADD: alu_wide = {1'b0, a_q} + {1'b0, b_q};
      OP_SUB: alu_wide = {1'b0, a_q} - {1'b0, b_q};
      OP_INC: alu_wide = {1'b0, a_q + 8'd1};
      OP_DEC: alu_wide = {1'b0, a_q - 8'd1};
      OP_AND: alu_wide = {1'b0, a_q & b_q};
      OP_OR:  alu_wide = {1'b0, a_q | b_q};
      OP_NOT: alu_wide = {1'b0, ~a_q};
      OP_XOR: alu_wide = {1'b0, a_q ^ b_q};
      OP_SL:  alu_wide = {1'b0, a_q[6:0], 1'b0};
      OP_SR:  alu_wide = {2'b00, a_q[7:1]};
      default: alu_wide = 9'd0;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // FSM next state and handshake/status outputs.
  always_comb begin
    state_nxt   = state;
    instr_ready = 1'b0;
    done        = 1'b0;
    illegal     = 1'b0;
    case (state)
      IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) state_nxt = READ;
      end
      READ: state_nxt = EXEC;
      EXEC: state_nxt = WB;
      WB: begin
        done      = 1'b1;
        illegal   = ~op_legal;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: loads and instruction latch in IDLE, operand fetch, execute, write-back.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) regs[i] <= REG_INIT;
      op_q  <= 4'd0;
      rd_q  <= 2'd0;
      rs_q  <= 2'd0;
      a_q   <= 8'd0;
      b_q   <= 8'd0;
      res_q <= 8'd0;
      cy_q  <= 1'b0;
      c_q   <= 1'b0;
      z_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (ld_en) regs[ld_addr] <= ld_data;
          if (instr_valid) begin
            op_q <= instr[7:4];
            rd_q <= instr[3:2];
            rs_q <= instr[1:0];
          end
        end
        READ: begin
          a_q <= regs[rd_q];
          b_q <= regs[rs_q];
        end
        EXEC: begin
          res_q <= alu_wide[7:0];
          cy_q  <= alu_wide[8];
        end
        WB: begin
          if (op_writes) begin
            regs[rd_q] <= res_q;
            z_q        <= (res_q == 8'd0);
            if (op_arith) c_q <= cy_q;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: doc/alu_seq.md
# alu_seq

Sequencer that owns the 8-bit `alu` datapath and drives it from a 4-entry register file. It accepts one 8-bit instruction per valid/ready handshake, reads operands, executes on `alu`, writes the result back, and maintains carry/zero flags. It sits between the instruction source and the ALU. A load port and a read port give register access for initialisation and observation.

## Interface
- `REG_INIT`, default 8'h00: reset value of all four registers R0–R3.
- `clk`  in  1: rising-edge clock.
- `rst`  in  1: synchronous, active-high reset.
- `instr_valid`  in  1: instruction offered.
- `instr_ready`  out  1: sequencer can accept an instruction.
- `instr`  in  8: [7:4] opcode, [3:2] rd (operand A and destination), [1:0] rs (operand B).
- `ld_en`  in  1: direct register write request.
- `ld_addr`  in  2: load target register.
- `ld_data`  in  8: load value.
- `rd_addr`  in  2: read-port register select.
- `rd_data`  out  8: R[rd_addr], combinational.
- `done`  out  1: one-cycle pulse when an instruction retires.
- `illegal`  out  1: one-cycle pulse, coincident with `done`, for an unsupported opcode.
- `flag_c`  out  1: carry/borrow flag.
- `flag_z`  out  1: zero flag.

## Operation
- Supported opcodes:
  - ADD 0000, SUB 0001, INC 0010, DEC 0100.
  - AND 1000, OR 1001, NOT 1010, XOR 1100.
  - SL 1110, SR 0111.
  - NOP 0110.
  - All other opcodes (0011, 0101, 1011, 1101, 1111) are illegal.
- FSM states: IDLE → READ → EXEC → WB → IDLE. No other transitions, except that `rst` forces IDLE from any state.
- IDLE:
  - `instr_ready`=1.
  - On `instr_valid`, latch `instr` and go to READ.
  - Otherwise stay in IDLE.
- READ: `a_q`←R[rd], `b_q`←R[rs].
- EXEC:
  - `alu` sees `a_q`, `b_q` and the latched opcode combinationally.
  - Register `res_q`←result and `cy_q`←carry_out.
- WB: `done`=1, then act by opcode class:
  - ADD, SUB: R[rd]←`res_q`; `flag_c`←`cy_q`; `flag_z`←(`res_q`==0).
  - Other legal, non-NOP ops: R[rd]←`res_q`; `flag_z`←(`res_q`==0); `flag_c` unchanged.
  - NOP: no write; flags unchanged.
  - Illegal: no write; flags unchanged; `illegal`=1. The ALU's high-Z output must never reach a register or a flag.
- Arithmetic: all results are modulo 256.
  - SUB: `flag_c`=1 exactly when A<B unsigned (borrow).
  - INC, DEC: wrap silently and do not touch `flag_c`.
  - SL, SR: logical shifts, zero fill.
- rd==rs is legal. Both operands read the same register, e.g. XOR R1,R1 → 0, Z=1.
- Load port:
  - Honoured only in IDLE; ignored in READ, EXEC and WB.
  - If `ld_en` and an instruction handshake occur in the same IDLE cycle, the load is written that cycle. The instruction's READ happens one cycle later and therefore sees the loaded value.
- `rd_data` reflects register contents after the clock edge. A WB or load write is visible the cycle after it happens.

## Timing
- Reset values:
  - State IDLE.
  - `instr_ready`=1, `done`=0, `illegal`=0, `flag_c`=0, `flag_z`=0.
  - R0–R3=`REG_INIT`.
  - `a_q`, `b_q`, `res_q`, `cy_q`=0.
- Handshake at edge N, with the FSM in IDLE during cycle N:
  - READ during cycle N+1.
  - EXEC during cycle N+2.
  - WB during cycle N+3: `done` is high and the register/flag update commits at the end of N+3.
  - IDLE again in cycle N+4 with `instr_ready`=1.
- Throughput is one instruction per 4 cycles, with no overlap.
- `instr_ready` is 0 in READ, EXEC and WB. `instr_valid` is ignored in those states, and `instr` need not be held after acceptance.
- `done` and `illegal` are each high for exactly one cycle per instruction.
- Reset during READ, EXEC or WB aborts the instruction:
  - No write-back, no `done`.
  - All state returns to reset values in the next cycle.

## Test plan
- **Reset:** assert `rst` for 2 cycles → `instr_ready`=1, flags 0, `done`=0, R0–R3 read as `REG_INIT`=8'h00 via `rd_data`.
- **ADD with carry:**
  - Stimulus: load R0=8'hF0, R1=8'h20, issue ADD rd=0 rs=1 (instr 8'h01).
  - Required: `done` exactly 3 cycles after the handshake cycle; R0=8'h10, C=1, Z=0; `instr_ready` low for 3 cycles.
- **SUB borrow then logic op:**
  - Stimulus: R2=8'h05, R3=8'h07; SUB rd=2 rs=3, then XOR rd=2 rs=2.
  - Required: after SUB, R2=8'hFE, C=1. After XOR, R2=8'h00, Z=1 and C still 1.
- **Illegal and NOP:**
  - Stimulus: R1=8'h3C; issue opcode 1111 rd=1, then NOP rd=1.
  - Required: `illegal` and `done` pulse together for the first instruction only; R1 stays 8'h3C; flags unchanged across both.
- **Load/handshake interaction:**
  - Stimulus: same IDLE cycle `ld_en` R1=8'h01 with INC rd=1 (instr 8'h24) → R1=8'h02.
  - Stimulus: `ld_en` during EXEC → ignored.
  - Stimulus: INC on 8'hFF → 8'h00, Z=1, C unchanged.
- **Reset mid-operation:**
  - Stimulus: assert `rst` in the EXEC cycle of SL on R0=8'h81.
  - Required: no `done`; R0=`REG_INIT`; the next instruction is accepted normally.
